// File: rtl/puf_chal_uart_rx.sv
// puf_chal_uart_rx: UART receiver that deserialises one challenge word per frame
// for the PUF controller (start, DW data bits LSB first, [even parity], stop).
// Ports: clk/rst_n (async active-low); i_rxd serial line (idle high, async);
//   i_dcod_ready controller can accept a word; o_rx_valid frame in flight or pending;
//   o_rx_ready no unconsumed word; o_rx_done one-cycle new-word pulse; o_rx_data word;
//   o_frame_err / o_parity_err one-cycle error pulses.
// Option: define PUF_RX_PARITY_EN to add an even-parity bit after the data bits.
module puf_chal_uart_rx #(
  parameter int MUX_LENGTH   = 16,
  parameter int CLKS_PER_BIT = 868,
  localparam int DW          = 2 * $clog2(MUX_LENGTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rxd,
  input  logic          i_dcod_ready,
  output logic          o_rx_valid,
  output logic          o_rx_ready,
  output logic          o_rx_done,
  output logic [DW-1:0] o_rx_data,
  output logic          o_frame_err,
  output logic          o_parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DW + 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef PUF_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    HOLD      = 3'd5,
    DONE      = 3'd6,
    WAIT_IDLE = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rxs_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
`ifdef PUF_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          par_bad_q, par_bad_d;
`endif

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= i_rxd;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef PUF_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef PUF_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef PUF_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif

    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          idx_d   = '0;
        end
      end
      // Sample mid start bit; a line already back high was a glitch.
      START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[DW-1:1]};
          idx_d   = idx_q + IW'(1);
          if (idx_q == LAST_BIT) begin
`ifdef PUF_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef PUF_RX_PARITY_EN
      PARITY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = rxs_q ^ (^shift_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (!rxs_q) begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
`ifdef PUF_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d  = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            state_d = i_dcod_ready ? DONE : HOLD;
          end
        end
      end
      // Line activity is ignored while a word waits for the controller.
      HOLD:      if (i_dcod_ready) state_d = DONE;
      DONE:      state_d = IDLE;
      WAIT_IDLE: if (rxs_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Word and done pulse are registered on entry so both appear in the DONE cycle.
    if (state_d == DONE) begin
      done_d = 1'b1;
      data_d = shift_q;
    end
  end

  assign valid_d = (state_d == DATA) || (state_d == STOP) || (state_d == HOLD) ||
`ifdef PUF_RX_PARITY_EN
                   (state_d == PARITY) ||
`endif
                   (state_d == DONE);
  assign ready_d = !((state_d == HOLD) || (state_d == DONE));

  assign o_rx_valid  = valid_q;
  assign o_rx_ready  = ready_q;
  assign o_rx_done   = done_q;
  assign o_rx_data   = data_q;
  assign o_frame_err = ferr_q;
`ifdef PUF_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
